muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have one parameter: XLEN, default 32, operand and result width; only 32 is supported.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-003 Ports SHALL be, one per line, as follows:
  clk  input  1  clock, rising edge
  rst_n  input  1  asynchronous active-low reset
  start_valid  input  1  operation request
  start_ready  output  1  block can accept a request
  op  input  2  00 MULU, 01 DIVU, 10 MULS, 11 DIVS
  x  input  XLEN  multiplicand or dividend
  y  input  XLEN  multiplier or divisor
  done_valid  output  1  result available
  done_ready  input  1  consumer accepts the result
  result  output  XLEN  product low word, or quotient
  result2  output  XLEN  product high word, or remainder
  div_by_zero  output  1  last divide had y == 0

Function
REQ-004 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-005 start_ready SHALL be 1 only in IDLE, and done_valid SHALL be 1 only in DONE.
REQ-006 A request SHALL be accepted on a clock edge where start_valid && start_ready; op, x and y SHALL be captured internally on that edge.
REQ-007 After acceptance the FSM SHALL move IDLE->BUSY.
REQ-008 BUSY SHALL perform exactly 32 radix-2 iterations, one per cycle, using a 6-bit counter: shift-add for multiply, restoring shift-subtract for divide.
REQ-009 After the 32nd iteration the FSM SHALL enter DONE, so done_valid rises 33 cycles after the accept edge.
REQ-010 result, result2 and div_by_zero SHALL stay stable in DONE until the edge where done_valid && done_ready, after which the FSM SHALL return to IDLE.
REQ-011 If done_ready is already high on entry to DONE, the block SHALL still hold DONE for at least one cycle.
REQ-012 No new request SHALL be accepted in the cycle a result is consumed; back-to-back throughput is one operation per 35 cycles.
REQ-013 start_valid SHALL be ignored while in BUSY or DONE, and x, y and op SHALL not be sampled in those states.
REQ-014 MULU SHALL produce {result2, result} = x * y as a full 64-bit unsigned product.
REQ-015 DIVU SHALL produce result = x / y and result2 = x % y, both unsigned.
REQ-016 For a divide with y == 0, the block SHALL skip the iterations and go BUSY->DONE after 1 cycle, with result = 32'hFFFF_FFFF, result2 = x and div_by_zero = 1.
REQ-017 div_by_zero SHALL be 0 for every other operation.
REQ-018 Internal accumulators SHALL be 64 bits for multiply and 33 bits for the trial subtraction in divide, with no truncation before the final result.

Reset
REQ-019 On rst_n low the block SHALL asynchronously go to IDLE and clear result, result2, div_by_zero, done_valid, the iteration counter and all captured operands to 0.
REQ-020 start_ready SHALL read 1 while in reset.
REQ-021 Reset asserted in BUSY or DONE SHALL abort the operation with no result delivered.
REQ-022 The first request SHALL be accepted no earlier than the first rising clk edge after rst_n deasserts.

Configuration
REQ-023 The block SHALL support one macro, MULDIV_SIGNED_EN, which compiles signed operation support in or out.
REQ-024 With MULDIV_SIGNED_EN defined:
  - MULS SHALL give the signed 64-bit product.
  - DIVS SHALL truncate the quotient toward zero and give the remainder the sign of the dividend.
  - Signs SHALL be handled by magnitude conversion on capture and negation on entry to DONE, with no extra cycles.
  - 32'h8000_0000 / 32'hFFFF_FFFF SHALL give result = 32'h8000_0000 and result2 = 0.
REQ-025 Without MULDIV_SIGNED_EN, op[1] SHALL be ignored, so MULS behaves as MULU and DIVS as DIVU, and no sign-handling logic SHALL be synthesized.

Verification
REQ-026 MULU with x=32'hFFFF_FFFF, y=32'hFFFF_FFFF -> after 33 cycles, result=32'h0000_0001 and result2=32'hFFFF_FFFE.
REQ-027 DIVU with x=100, y=7 -> result=14 and result2=2; hold done_ready low for 10 cycles and outputs stay stable, then one handshake returns the block to IDLE with start_ready=1 on the next cycle.
REQ-028 DIVU with x=5, y=0 -> done_valid 2 cycles after accept, result=32'hFFFF_FFFF, result2=5, div_by_zero=1.
REQ-029 With MULDIV_SIGNED_EN: DIVS with x=-7, y=2 -> result=-3 and result2=-1; MULS with x=-2, y=3 -> result=32'hFFFF_FFFA and result2=32'hFFFF_FFFF; without the macro, the same MULS gives result2=32'h0000_0002.
REQ-030 Assert rst_n low at iteration 16 of a MULU -> all outputs read 0 and start_ready reads 1 immediately; a subsequent MULU 3*4 gives result=12.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential radix-2 multiplier / divider.
//
// One operation at a time. A request is captured in IDLE, BUSY runs 32 iterations
// (shift-add for multiply, restoring shift-subtract for divide) and DONE holds the result
// until the consumer takes it. done_valid rises 33 cycles after the accept edge
// (2 cycles for a divide by zero).
//
// Optional feature macro: MULDIV_SIGNED_EN
//   defined   -> op[1] selects signed MULS / DIVS (magnitude on capture, negate on finish)
//   undefined -> op[1] is ignored and no sign logic exists
//
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   start_valid   request strobe, accepted when start_ready is high
//   start_ready   high only in IDLE (and while in reset)
//   op            00 MULU, 01 DIVU, 10 MULS, 11 DIVS
//   x, y          multiplicand/dividend, multiplier/divisor
//   done_valid    result available (DONE state)
//   done_ready    consumer accepts the result
//   result        product low word or quotient
//   result2       product high word or remainder
//   div_by_zero   last divide had y == 0

`timescale 1ns/1ps

module muldiv_seq #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] x,
    input  logic [XLEN-1:0] y,
    output logic            done_valid,
    input  logic            done_ready,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] result2,
    output logic            div_by_zero
);

    localparam int unsigned W2      = 2 * XLEN;
    localparam logic [5:0]  LastCnt = 6'(XLEN);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q;
    logic [5:0]      cnt_q;
    // Multiply: {high, low} product, low half initially holds the multiplier.
    // Divide:   {remainder, dividend/quotient}.
    logic [W2-1:0]   acc_q;
    // Multiplicand for multiply, divisor for divide.
    logic [XLEN-1:0] opnd_q;
    logic            is_div_q;
    logic            dbz_q;
`ifdef MULDIV_SIGNED_EN
    logic            neg_lo_q;  // negate product / quotient on finish
    logic            neg_hi_q;  // negate remainder on finish
`endif

    // Operand capture (magnitudes when signed support is compiled in).
    logic [XLEN-1:0] x_mag, y_mag;
`ifdef MULDIV_SIGNED_EN
    logic x_neg, y_neg;
`else
    logic unused_op1;
    assign unused_op1 = op[1];
`endif

    always_comb begin
        x_mag = x;
        y_mag = y;
`ifdef MULDIV_SIGNED_EN
        x_neg = op[1] & x[XLEN-1];
        y_neg = op[1] & y[XLEN-1];
        if (x_neg) x_mag = -x;
        if (y_neg) y_mag = -y;
`endif
    end

    // One iteration of each algorithm.
    logic [XLEN-1:0] mul_addend;
    logic [XLEN:0]   mul_sum;
    logic [W2-1:0]   mul_next;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
    logic            div_ge;
    logic [W2-1:0]   div_next;

    always_comb begin
        mul_addend = acc_q[0] ? opnd_q : {XLEN{1'b0}};
        mul_sum    = {1'b0, acc_q[W2-1:XLEN]} + {1'b0, mul_addend};
        mul_next   = {mul_sum, acc_q[XLEN-1:1]};

        // remainder < divisor always holds, so a 33-bit trial cannot overflow and its
        // top bit is the borrow.
        div_shift  = acc_q[W2-1:XLEN-1];
        div_diff   = div_shift - {1'b0, opnd_q};
        div_ge     = ~div_diff[XLEN];
        div_next   = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                      acc_q[XLEN-2:0], div_ge};
    end

    // Final values presented on entry to DONE.
    logic [W2-1:0]   fin_prod;
    logic [XLEN-1:0] fin_quo, fin_rem;
    logic [XLEN-1:0] fin_res, fin_res2;

    always_comb begin
        fin_prod = acc_q;
        fin_quo  = acc_q[XLEN-1:0];
        fin_rem  = acc_q[W2-1:XLEN];
`ifdef MULDIV_SIGNED_EN
        if (neg_lo_q) begin
            fin_prod = -acc_q;
            fin_quo  = -acc_q[XLEN-1:0];
        end
        if (neg_hi_q) fin_rem = -acc_q[W2-1:XLEN];
`endif
        if (is_div_q) begin
            fin_res  = dbz_q ? {XLEN{1'b1}} : fin_quo;
            fin_res2 = fin_rem;
        end else begin
            fin_res  = fin_prod[XLEN-1:0];
            fin_res2 = fin_prod[W2-1:XLEN];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            acc_q       <= '0;
            opnd_q      <= '0;
            is_div_q    <= 1'b0;
            dbz_q       <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_lo_q    <= 1'b0;
            neg_hi_q    <= 1'b0;
`endif
            start_ready <= 1'b1;
            done_valid  <= 1'b0;
            result      <= '0;
            result2     <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_valid) begin
                        is_div_q    <= op[0];
                        opnd_q      <= op[0] ? y_mag : x_mag;
                        acc_q       <= {{XLEN{1'b0}}, (op[0] ? x_mag : y_mag)};
                        dbz_q       <= 1'b0;
                        cnt_q       <= '0;
`ifdef MULDIV_SIGNED_EN
                        neg_lo_q    <= x_neg ^ y_neg;
                        neg_hi_q    <= op[0] ? x_neg : (x_neg ^ y_neg);
`endif
                        start_ready <= 1'b0;
                        state_q     <= StBusy;
                    end
                end
                StBusy: begin
                    if (cnt_q == LastCnt) begin
                        result      <= fin_res;
                        result2     <= fin_res2;
                        div_by_zero <= dbz_q;
                        done_valid  <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= StDone;
                    end else if (cnt_q == '0 && is_div_q && opnd_q == '0) begin
                        // Divide by zero: park the dividend in the remainder half, skip
                        // the iterations and finish on the next edge.
                        acc_q <= {acc_q[XLEN-1:0], {XLEN{1'b1}}};
                        dbz_q <= 1'b1;
                        cnt_q <= LastCnt;
                    end else begin
                        acc_q <= is_div_q ? div_next : mul_next;
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                StDone: begin
                    if (done_ready) begin
                        done_valid  <= 1'b0;
                        start_ready <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    done_valid  <= 1'b0;
                    start_ready <= 1'b1;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
`timescale 1ns/1ps

module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [1:0]  op = 2'b00;
    logic [31:0] x = '0;
    logic [31:0] y = '0;
    logic        done_valid;
    logic        done_ready = 1'b0;
    logic [31:0] result;
    logic [31:0] result2;
    logic        div_by_zero;

    muldiv_seq #(.XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op          (op),
        .x           (x),
        .y           (y),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .result      (result),
        .result2     (result2),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] r;
        logic [31:0] r2;
        logic        dbz;
        int unsigned lat;
        int unsigned acc;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   hold   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: plain arithmetic on the architectural definition of each op.
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t        e;
        logic        s;
        logic [63:0] p;
        longint      la, lb;
        s = 1'b0;
`ifdef MULDIV_SIGNED_EN
        s = o[1];
`endif
        e.dbz = 1'b0;
        e.lat = 33;
        e.acc = 0;
        if (!o[0]) begin
            if (s) begin
                la = longint'($signed(a));
                lb = longint'($signed(b));
                p  = 64'(la * lb);
            end else begin
                p = {32'b0, a} * {32'b0, b};
            end
            e.r  = p[31:0];
            e.r2 = p[63:32];
        end else if (b == 32'd0) begin
            e.r   = 32'hFFFF_FFFF;
            e.r2  = a;
            e.dbz = 1'b1;
            e.lat = 2;
        end else if (s) begin
            la   = longint'($signed(a));
            lb   = longint'($signed(b));
            e.r  = 32'(la / lb);
            e.r2 = 32'(la % lb);
        end else begin
            e.r  = a / b;
            e.r2 = a % b;
        end
        return e;
    endfunction

    // Issue one request; optionally wiggle the inputs while BUSY to show they are ignored.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int holdc, input bit junk);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!start_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!start_ready) begin
            checks++;
            errors++;
            $display("FAIL start_ready_timeout actual=0 required=1");
            return;
        end
        start_valid = 1'b1;
        op = o;
        x  = a;
        y  = b;
        e = model(o, a, b);
        e.acc = cyc + 1;
        hold = holdc;
        sbq.push_back(e);
        @(negedge clk);
        if (junk && !(o[0] && b == 32'd0)) begin
            repeat (3) begin
                op = 2'($urandom_range(3));
                x  = $urandom;
                y  = $urandom;
                @(negedge clk);
            end
        end
        start_valid = 1'b0;
    endtask

    // Monitor + done_ready driver in one process so the handshake prediction is exact.
    initial begin : monitor
        exp_t e;
        bit   prev_dv;
        bit   exp_idle;
        prev_dv  = 1'b0;
        exp_idle = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_dv  = 1'b0;
                exp_idle = 1'b0;
            end else begin
                if (exp_idle) begin
                    check("idle_start_ready", 64'(start_ready), 64'd1);
                    check("idle_done_valid", 64'(done_valid), 64'd0);
                    exp_idle = 1'b0;
                end
                if (done_valid && hold > 0) begin
                    done_ready = 1'b0;
                    hold--;
                end else begin
                    done_ready = ($urandom_range(3) != 0);
                end
                if (done_valid) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done actual=1 required=0");
                    end else begin
                        e = sbq[0];
                        if (!prev_dv) check("latency", 64'(cyc - e.acc), 64'(e.lat));
                        check("result", 64'(result), 64'(e.r));
                        check("result2", 64'(result2), 64'(e.r2));
                        check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
                        check("start_ready_in_done", 64'(start_ready), 64'd0);
                        if (done_ready) begin
                            void'(sbq.pop_front());
                            exp_idle = 1'b1;
                        end
                    end
                end
                prev_dv = done_valid;
            end
        end
    end

    initial begin : stim
        logic [1:0]  o;
        logic [31:0] a, b;
        int          n;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_start_ready", 64'(start_ready), 64'd1);
        check("rst_done_valid", 64'(done_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_result2", 64'(result2), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1);
        issue(2'b01, 32'd100, 32'd7, 10, 1'b1);
        issue(2'b01, 32'd5, 32'd0, 0, 1'b0);
        issue(2'b10, 32'hFFFF_FFFE, 32'd3, 0, 1'b0);
        issue(2'b11, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        issue(2'b11, 32'hFFFF_FFF7, 32'd0, 0, 1'b0);
        issue(2'b10, 32'h8000_0000, 32'h8000_0000, 0, 1'b0);

        // Reset in the middle of a multiply aborts it without a result.
        issue(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1'b0);
        repeat (15) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_result", 64'(result), 64'd0);
        check("abort_result2", 64'(result2), 64'd0);
        check("abort_dbz", 64'(div_by_zero), 64'd0);
        check("abort_done_valid", 64'(done_valid), 64'd0);
        check("abort_start_ready", 64'(start_ready), 64'd1);
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(2'b00, 32'd3, 32'd4, 0, 1'b0);

        // Randomized operations.
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(9))
                0: b = 32'd0;
                1: b = 32'($urandom_range(15));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: a = 32'($urandom_range(255));
                default: ;
            endcase
            issue(o, a, b, int'($urandom_range(3)), 1'b1);
        end

        n = 0;
        while (sbq.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(sbq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
